// File: rtl/decoder_pkg.sv
// Shared definitions for the sequential one-hot decoder.
// Contents:
//   state_e - control FSM state; StIdle = 0, StBurst = 1.
package decoder_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_n.sv
// Combinational N-to-2**N one-hot decoder.
// Ports:
//   addr   - N-bit binary index
//   onehot - 2**N-bit vector with only bit [addr] set
module decoder_n #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]        addr,
  output logic [(1<<N)-1:0]   onehot
);

  always_comb begin
    onehot       = '0;
    onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered one-hot decoder with single and incrementing-burst requests.
// A single request yields one beat; a burst yields Len+1 beats at consecutive
// addresses (wrapping modulo 2**N), one beat per cycle while En is high.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   In, Len, Burst      - request start address, beats minus one, mode
//   In_valid / In_ready - request handshake (In_ready is combinational)
//   En                  - advance enable; low stalls and blanks the next beat
//   Out, Out_valid      - registered one-hot beat and its qualifier
//   Last                - final beat of the current request
//   Busy                - a burst is still producing beats
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        In,
  input  logic [N-1:0]        Len,
  input  logic                Burst,
  input  logic                In_valid,
  output logic                In_ready,
  input  logic                En,
  output logic [(1<<N)-1:0]   Out,
  output logic                Out_valid,
  output logic                Last,
  output logic                Busy
);

  localparam int unsigned W = 1 << N;

  state_e         state_q, state_d;
  logic [N-1:0]   addr_q, addr_d;
  logic [N-1:0]   cnt_q, cnt_d;
  // Set for the cycle carrying a burst's final beat: the FSM is already back in
  // StIdle then, but a new request must wait one more cycle.
  logic           cool_q, cool_d;
  logic [W-1:0]   out_q, out_d;
  logic           valid_q, last_q;
  logic           emit, last_d;
  logic           accept, multi;
  logic [W-1:0]   onehot;

  assign In_ready = rst_n & En & (state_q == StIdle) & ~cool_q;
  assign accept   = In_valid & In_ready;
  // A burst of one beat behaves exactly like a single decode.
  assign multi    = Burst & (Len != '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    cool_d  = 1'b0;
    emit    = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d = In;
          emit   = 1'b1;
          if (multi) begin
            cnt_d   = Len;
            state_d = StBurst;
          end else begin
            cnt_d  = '0;
            last_d = 1'b1;
          end
        end
      end
      StBurst: begin
        if (En) begin
          addr_d = addr_q + N'(1);
          cnt_d  = cnt_q - N'(1);
          emit   = 1'b1;
          if (cnt_d == '0) begin
            last_d  = 1'b1;
            cool_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  decoder_n #(
    .N (N)
  ) u_decoder_n (
    .addr   (addr_d),
    .onehot (onehot)
  );

  assign out_d = emit ? onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      cool_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
      out_q   <= out_d;
      valid_q <= emit;
      last_q  <= last_d;
    end
  end

  assign Out       = out_q;
  assign Out_valid = valid_q;
  assign Last      = last_q;
  assign Busy      = (state_q == StBurst);

endmodule

// File: tb/tb_decoder_n_seq.sv
// Self-checking bench for decoder_n_seq: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_decoder_n_seq;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_a, len;
  logic         burst, in_valid, en;
  logic         in_ready;
  logic [W-1:0] dut_out;
  logic         out_valid, last, busy;

  // Second instance at N=4 for the full-wrap burst.
  logic [3:0]   in2, len2;
  logic         burst2, valid2, en2, ready2;
  logic [15:0]  out2;
  logic         ov2, last2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_n_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (in_a),
    .Len       (len),
    .Burst     (burst),
    .In_valid  (in_valid),
    .In_ready  (in_ready),
    .En        (en),
    .Out       (dut_out),
    .Out_valid (out_valid),
    .Last      (last),
    .Busy      (busy)
  );

  decoder_n_seq #(.N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (in2),
    .Len       (len2),
    .Burst     (burst2),
    .In_valid  (valid2),
    .In_ready  (ready2),
    .En        (en2),
    .Out       (out2),
    .Out_valid (ov2),
    .Last      (last2),
    .Busy      (busy2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of beat addresses still owed by the current burst.
  int           q[$];
  logic         cool_m = 1'b0;
  logic [W-1:0] exp_out = '0;
  logic         exp_valid = 1'b0, exp_last = 1'b0, exp_busy = 1'b0;
  logic [W-1:0] one8 = 8'd1;
  int           a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cool_m    = 1'b0;
      exp_out   = '0;
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      logic rdy, cool_n;
      rdy       = en && (q.size() == 0) && !cool_m;
      cool_n    = 1'b0;
      exp_out   = '0;
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      if (en) begin
        if (q.size() > 0) begin
          a         = q.pop_front();
          exp_out   = one8 << a;
          exp_valid = 1'b1;
          exp_last  = (q.size() == 0);
          cool_n    = exp_last;
        end else if (rdy && in_valid) begin
          exp_out   = one8 << in_a;
          exp_valid = 1'b1;
          if (burst && len != 0)
            for (int k = 1; k <= int'(len); k++) q.push_back((int'(in_a) + k) % W);
          exp_last  = (q.size() == 0);
        end
      end
      cool_m   = cool_n;
      exp_busy = (q.size() > 0);
    end
  end

  // Compare process: mid-cycle, every cycle.
  always @(negedge clk) begin
    check("out", 64'(dut_out), 64'(exp_out));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("last", 64'(last), 64'(exp_last));
    check("busy", 64'(busy), 64'(exp_busy));
    check("in_ready", 64'(in_ready), 64'(rst_n && en && q.size() == 0 && !cool_m));
    check("onehot", 64'($countones(dut_out) <= 1), 64'(1));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] ad, input logic [N-1:0] l,
                       input logic b, input logic e);
    in_valid = v;
    in_a     = ad;
    len      = l;
    burst    = b;
    en       = e;
  endtask

  initial begin
    int busy_cnt;
    int seq4[4];
    seq4 = '{6, 7, 0, 1};
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    in2 = '0; len2 = '0; burst2 = 1'b0; valid2 = 1'b0; en2 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out", 64'(dut_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Single In=5, request already presented while in reset.
    cyc();
    drive(1'b1, 3'd5, 3'd7, 1'b0, 1'b1);
    check("rst_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    cyc();
    check("single_out", 64'(dut_out), 64'(8'b0010_0000));
    check("single_last", 64'({out_valid, last}), 64'(2'b11));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
    check("single_after", 64'(dut_out), 64'(0));

    // Burst In=6 Len=3 wraps 6,7,0,1.
    drive(1'b1, 3'd6, 3'd3, 1'b1, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check("burst_out", 64'(dut_out), 64'(one8 << seq4[i]));
      check("burst_last", 64'(last), 64'(i == 3));
      if (busy) busy_cnt++;
    end
    check("burst_busy_cycles", 64'(busy_cnt), 64'(3));
    cyc();

    // Burst In=2 Len=2 stalled two cycles after the first beat.
    drive(1'b1, 3'd2, 3'd2, 1'b1, 1'b1);
    cyc();
    check("stall_b0", 64'(dut_out), 64'(8'h04));
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    check("stall_gap0", 64'({dut_out, out_valid}), 64'(0));
    cyc();
    check("stall_gap1", 64'({dut_out, out_valid}), 64'(0));
    en = 1'b1;
    cyc();
    check("stall_b1", 64'(dut_out), 64'(8'h08));
    cyc();
    check("stall_b2", 64'({dut_out, last}), 64'({8'h10, 1'b1}));
    cyc();

    // Reset mid-burst In=0 Len=7 after three beats.
    drive(1'b1, 3'd0, 3'd7, 1'b1, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
    cyc();
    check("abort_pre", 64'(dut_out), 64'(8'h04));
    #1 rst_n = 1'b0;
    #1;
    check("abort_out", 64'({dut_out, out_valid}), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    cyc();
    rst_n = 1'b1;
    cyc();
    check("abort_no_beat", 64'({dut_out, out_valid}), 64'(0));
    drive(1'b1, 3'd1, 3'd0, 1'b0, 1'b1);
    cyc();
    check("abort_new", 64'(dut_out), 64'(8'b0000_0010));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();

    // In_valid held through a burst and its Last beat.
    drive(1'b1, 3'd3, 3'd1, 1'b1, 1'b1);
    cyc();
    check("hold_b0", 64'(dut_out), 64'(8'h08));
    drive(1'b1, 3'd5, 3'd0, 1'b0, 1'b1);
    cyc();
    check("hold_last", 64'({dut_out, last}), 64'({8'h10, 1'b1}));
    check("hold_ready_last", 64'(in_ready), 64'(0));
    cyc();
    check("hold_gap", 64'(dut_out), 64'(0));
    check("hold_ready", 64'(in_ready), 64'(1));
    cyc();
    check("hold_new", 64'(dut_out), 64'(8'h20));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();

    // N=4 burst covering all 16 outputs.
    in2 = 4'd0; len2 = 4'd15; burst2 = 1'b1; valid2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      valid2 = 1'b0;
      check("n4_out", 64'(out2), 64'(64'd1 << i));
      check("n4_onehot", 64'($countones(out2)), 64'(1));
      check("n4_last", 64'(last2), 64'(i == 15));
    end
    cyc();
    check("n4_done", 64'({out2, ov2, busy2}), 64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
